// File: rtl/keypad_if.sv
// Keypad matrix and MCU handshake bundle for keypad_scan_ctrl.
// The controller uses the slave modport; the MCU/keypad side uses master.
interface keypad_if;
  logic [2:0] COLS;
  logic [3:0] ROWS;
  logic [7:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_ACK;
  logic       KEY_INTR;
  logic       OVERRUN;

  modport master (
    output COLS,
    output KEY_ACK,
    input  ROWS,
    input  KEY_CODE,
    input  KEY_VALID,
    input  KEY_INTR,
    input  OVERRUN
  );

  modport slave (
    input  COLS,
    input  KEY_ACK,
    output ROWS,
    output KEY_CODE,
    output KEY_VALID,
    output KEY_INTR,
    output OVERRUN
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row sequencing, press/release debounce, and a single
// latched key code per press handed to the MCU via valid/ack plus an interrupt pulse.
module keypad_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 8333,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  keypad_if.slave kp
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] StScan     = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHeld     = 2'd2;

  logic [2:0]      cols_meta_q, cols_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      cand_code_q, cand_code_d;
  logic [2:0]      cand_cols_q, cand_cols_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_intr_q, key_intr_d;
  logic            overrun_q, overrun_d;

  logic       tick;
  logic       latch;
  logic       dec_valid;
  logic [1:0] col_idx;
  logic [7:0] dec_code;

  assign tick = (div_q == DivMax);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Only a single set column bit is a key; 000 and multi-bit patterns are ignored.
  always_comb begin
    dec_valid = 1'b1;
    col_idx   = 2'd0;
    case (cols_sync_q)
      3'b001:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: dec_valid = 1'b0;
    endcase
    if (row_q == 2'd3) begin
      case (col_idx)
        2'd0:    dec_code = 8'h0A;
        2'd1:    dec_code = 8'h00;
        default: dec_code = 8'h0B;
      endcase
    end else begin
      dec_code = ({6'd0, row_q} * 8'd3) + {6'd0, col_idx} + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    cand_code_d = cand_code_q;
    cand_cols_d = cand_cols_q;
    latch       = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (dec_valid) begin
            cand_code_d = dec_code;
            cand_cols_d = cols_sync_q;
            cnt_d       = '0;
            state_d     = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        StDebounce: begin
          if (cols_sync_q == cand_cols_q) begin
            if (cnt_q == DebLast) begin
              latch   = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = StScan;
          end
        end
        StHeld: begin
          // Release needs DEBOUNCE_TICKS consecutive all-zero samples.
          if (cols_sync_q == 3'b000) begin
            if (cnt_q == DebLast) begin
              cnt_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = StScan;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StScan;
        end
      endcase
    end
  end

  // A latch in the same cycle as an ack wins; the ack only consumes the old code.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    key_intr_d  = latch;
    if (latch) begin
      key_code_d  = cand_code_q;
      key_valid_d = 1'b1;
      if (kp.KEY_ACK) begin
        overrun_d = 1'b0;
      end else if (key_valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (kp.KEY_ACK && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cols_meta_q <= 3'b000;
      cols_sync_q <= 3'b000;
      div_q       <= '0;
      row_q       <= 2'd0;
      state_q     <= StScan;
      cnt_q       <= '0;
      cand_code_q <= 8'hFF;
      cand_cols_q <= 3'b000;
      key_code_q  <= 8'hFF;
      key_valid_q <= 1'b0;
      key_intr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cols_meta_q <= kp.COLS;
      cols_sync_q <= cols_meta_q;
      div_q       <= div_d;
      row_q       <= row_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_code_q <= cand_code_d;
      cand_cols_q <= cand_cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_intr_q  <= key_intr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign kp.ROWS      = 4'b0001 << row_q;
  assign kp.KEY_CODE  = key_code_q;
  assign kp.KEY_VALID = key_valid_q;
  assign kp.KEY_INTR  = key_intr_q;
  assign kp.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized bench for keypad_scan_ctrl: emulated key matrix, tick-level reference
// model, and a scoreboard of expected key events popped on each KEY_INTR.
module tb_keypad_scan_ctrl;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Deb    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if kp ();

  keypad_scan_ctrl #(
    .CLK_DIV       (ClkDiv),
    .DEBOUNCE_TICKS(Deb)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ovr;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;

  // Reference model state (abstract: scanning / debouncing / held as two flags).
  int         m_row = 0, m_div = 0, m_agree = 0, m_quiet = 0;
  bit         m_frozen = 1'b0, m_held = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_intr = 1'b0;
  bit         m_latch = 1'b0;
  logic [7:0] m_code = 8'hFF, m_cand = 8'hFF;
  logic [2:0] m_cand_cols = 3'b000, m_s1 = 3'b000, m_s2 = 3'b000;
  int         key_tbl[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  // Matrix emulation controls.
  bit         pressing = 1'b0;
  int         press_row = 0;
  logic [2:0] press_cols = 3'b001;
  int         bounce_pct = 0;
  int         ack_pct = 0;

  function automatic int col_of(input logic [2:0] c);
    return c[0] ? 0 : (c[1] ? 1 : 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_latch = 1'b0;
    if (!rst_n) begin
      m_row = 0; m_div = 0; m_agree = 0; m_quiet = 0;
      m_frozen = 1'b0; m_held = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_intr = 1'b0;
      m_code = 8'hFF; m_s1 = 3'b000; m_s2 = 3'b000;
      sb_q.delete();
    end else begin
      if (m_div == ClkDiv - 1) begin
        if (!m_frozen) begin
          if ($countones(m_s2) == 1) begin
            m_cand      = 8'(key_tbl[m_row * 3 + col_of(m_s2)]);
            m_cand_cols = m_s2;
            m_agree     = 0;
            m_frozen    = 1'b1;
            m_held      = 1'b0;
          end else begin
            m_row = (m_row + 1) % 4;
          end
        end else if (!m_held) begin
          if (m_s2 == m_cand_cols) begin
            m_agree++;
            if (m_agree == Deb) begin
              m_latch = 1'b1;
              m_held  = 1'b1;
              m_quiet = 0;
            end
          end else begin
            m_frozen = 1'b0;
            m_row    = (m_row + 1) % 4;
          end
        end else begin
          m_quiet = (m_s2 == 3'b000) ? m_quiet + 1 : 0;
          if (m_quiet == Deb) begin
            m_frozen = 1'b0;
            m_held   = 1'b0;
            m_row    = (m_row + 1) % 4;
          end
        end
        m_div = 0;
      end else begin
        m_div++;
      end
      if (m_latch) begin
        m_ovr   = kp.KEY_ACK ? 1'b0 : (m_valid ? 1'b1 : m_ovr);
        m_valid = 1'b1;
        m_code  = m_cand;
        sb_q.push_back('{code: m_cand, ovr: m_ovr});
      end else if (kp.KEY_ACK && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      m_intr = m_latch;
      m_s2   = m_s1;
      m_s1   = kp.COLS;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("rows", kp.ROWS, 4'b0001 << m_row);
      check("valid", kp.KEY_VALID, m_valid);
      check("overrun", kp.OVERRUN, m_ovr);
      check("code", kp.KEY_CODE, m_code);
      check("intr", kp.KEY_INTR, m_intr);
      if (kp.KEY_INTR) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_intr: got code %0h expected no event", kp.KEY_CODE);
        end else begin
          e = sb_q.pop_front();
          check("sb_code", kp.KEY_CODE, e.code);
          check("sb_ovr", kp.OVERRUN, e.ovr);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (pressing && kp.ROWS == (4'b0001 << press_row) &&
        !($urandom_range(0, 99) < bounce_pct))
      kp.COLS = press_cols;
    else
      kp.COLS = 3'b000;
    kp.KEY_ACK = ($urandom_range(0, 99) < ack_pct);
  endtask

  initial begin
    int         kind;
    logic [2:0] junk[4];
    junk = '{3'b011, 3'b101, 3'b110, 3'b111};
    kp.COLS    = 3'b000;
    kp.KEY_ACK = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rows", kp.ROWS, 4'b0001);
    check("rst_code", kp.KEY_CODE, 8'hFF);
    check("rst_valid", kp.KEY_VALID, 1'b0);
    check("rst_intr", kp.KEY_INTR, 1'b0);
    check("rst_ovr", kp.OVERRUN, 1'b0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (24) cyc();

    for (int it = 0; it < 60; it++) begin
      kind       = int'($urandom_range(0, 9));
      press_row  = int'($urandom_range(0, 3));
      press_cols = 3'b001 << $urandom_range(0, 2);
      if (kind == 0) press_cols = junk[$urandom_range(0, 3)];
      bounce_pct = (kind >= 1 && kind <= 2) ? 35 : 0;
      case ($urandom_range(0, 2))
        0:       ack_pct = 0;
        1:       ack_pct = 5;
        default: ack_pct = 50;
      endcase
      pressing = 1'b1;
      if (it == 30) begin
        // Long clean press so the reset lands while the key is held.
        bounce_pct = 0;
        press_cols = 3'b010;
        repeat (90) cyc();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        check("midrst_rows", kp.ROWS, 4'b0001);
        check("midrst_code", kp.KEY_CODE, 8'hFF);
        check("midrst_valid", kp.KEY_VALID, 1'b0);
      end
      repeat ($urandom_range(30, 150)) cyc();
      pressing = 1'b0;
      repeat ($urandom_range(16, 48)) cyc();
    end

    ack_pct = 0;
    repeat (40) cyc();
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x3 keypad matrix by driving one row at a time from a divided scan tick.
- Debounces press and release, and latches a single key code per press.
- Presents the code to the RAT MCU through a valid/ack handshake plus a one-cycle interrupt pulse.
- Replaces free-running combinational decode with one debounced event per physical press.

Parameters:
- CLK_DIV, 8333: clk cycles per scan tick (12 kHz tick from a 100 MHz clk); legal range >= 2.
- DEBOUNCE_TICKS, 4: consecutive identical tick samples required to accept a press or a release; legal range >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- COLS  in  3  keypad column inputs, asynchronous, active-high one-hot when pressed.
- ROWS  out  4  row drive, active-high one-hot.
- KEY_CODE  out  8  latched key code.
- KEY_VALID  out  1  high while KEY_CODE is unread.
- KEY_ACK  in  1  MCU read strobe.
- KEY_INTR  out  1  one-clk pulse when a new code is latched.
- OVERRUN  out  1  sticky flag: a code was overwritten before ack.

Behaviour:
- Reset (rst_n low at a clk edge): ROWS=4'b0001, KEY_CODE=8'hFF, KEY_VALID=0, KEY_INTR=0, OVERRUN=0; row index 0, divider 0, debounce count 0, state SCAN.
- COLS passes through a 2-flop synchronizer before use.
- Divider: counts 0..CLK_DIV-1. The tick is a one-clk pulse while the count equals CLK_DIV-1; the count then wraps to 0.
- Row advance: ROWS updates on the clk after a tick. Each row is therefore held a full tick period before it is sampled.
- Decode of synchronized COLS against the current row (COLS 001/010/100):
  - row0 -> 01/02/03
  - row1 -> 04/05/06
  - row2 -> 07/08/09
  - row3 -> 0A/00/0B
  - Any non-one-hot COLS (000, or multiple bits set) is "no key".
- FSM, all transitions evaluated on tick only:
  - SCAN: if the current row decodes a valid key, store the candidate code and column, clear the debounce count, go to DEBOUNCE, and freeze the row. Otherwise advance the row 0->1->2->3->0.
  - DEBOUNCE: if COLS equals the stored column, increment the count. When the count reaches DEBOUNCE_TICKS-1, latch the event and go to HELD. Any mismatch returns to SCAN and advances the row. With DEBOUNCE_TICKS=1, the latch occurs on the first DEBOUNCE tick.
  - HELD: the row stays frozen. COLS=000 increments the release count and any nonzero COLS clears it. When the count reaches DEBOUNCE_TICKS, go to SCAN, advance the row, and clear the count. No new event is generated while in HELD.
- Latch event, same clk as the tick:
  - KEY_CODE takes the candidate value on the next edge, KEY_VALID goes to 1, and KEY_INTR goes to 1 for exactly one clk.
  - If KEY_VALID was already 1 with no ack in that cycle, OVERRUN is set to 1.
- Ack:
  - KEY_ACK high with no concurrent latch: KEY_VALID and OVERRUN clear on the next edge. KEY_CODE holds its value.
  - Ack and latch in the same cycle: the latch wins, KEY_VALID stays 1, and OVERRUN is cleared (the old code was consumed).
  - KEY_ACK while KEY_VALID=0: no effect.
- Reset mid-operation returns to the reset state from any FSM state. A pending code is discarded.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3):
1. Reset, no keys pressed -> ROWS cycles 0001->0010->0100->1000->0001, each row held 4 clk. KEY_VALID=0, KEY_CODE=FF.
2. COLS=010 held while row1 is active for more than 3 ticks -> ROWS freezes at 0010. KEY_CODE=05, KEY_VALID=1, and a single KEY_INTR pulse at the third tick. Release for 3 ticks -> ROWS resumes at 0100.
3. COLS=001 on row3 for 2 ticks, then bouncing to 000 -> no KEY_INTR, and scanning resumes. A later stable press on row3 gives KEY_CODE=0A.
4. Press "9" and latch it, no ack, then press "1" and latch it -> KEY_CODE=01, OVERRUN=1. Pulse KEY_ACK -> KEY_VALID=0 and OVERRUN=0 next clk.
5. KEY_ACK asserted in the same clk as the latch of "0" (row3, COLS=010) -> KEY_CODE=00, KEY_VALID stays 1, OVERRUN=0.
6. COLS=011 on row2, and separately rst_n pulsed low during HELD -> no event for 011. After reset, ROWS=0001, KEY_CODE=FF, KEY_VALID=0.
